tt_sweep_ctrl: RTL



---
 rtl/tt_sweep_pkg.sv | 20 ++
 rtl/tt_sweep_ctrl_if.sv | 27 ++
 rtl/tt_settle_timer.sv | 31 +++
 rtl/tt_sweep_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared types and constants for the truth-table sweep controller
package tt_sweep_pkg;

    localparam int TT_W = 8;
    localparam int N_IN = 3;

    localparam logic [TT_W-1:0] TT_0X72 = 8'h72;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    // Row 000 lands in the MSB of the truth-table code.
    function automatic logic [N_IN-1:0] vec_to_bit(input logic [N_IN-1:0] v);
        return 3'd7 - v;
    endfunction

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// rtl/tt_sweep_ctrl_if.sv - host and gate-under-test signals of the sweep controller
interface tt_sweep_ctrl_if;
    import tt_sweep_pkg::*;

    logic              start;
    logic              abort;
    logic [TT_W-1:0]   expected_tt;
    logic [N_IN-1:0]   gate_in;
    logic              gate_out;
    logic              busy;
    logic              done;
    logic [TT_W-1:0]   tt_result;
    logic              tt_valid;
    logic              match;
    logic              unstable;

    modport master (
        output start, abort, expected_tt, gate_out,
        input  gate_in, busy, done, tt_result, tt_valid, match, unstable
    );

    modport slave (
        input  start, abort, expected_tt, gate_out,
        output gate_in, busy, done, tt_result, tt_valid, match, unstable
    );

endinterface

// File: rtl/tt_settle_timer.sv
// rtl/tt_settle_timer.sv - loadable settle down-counter; one-before-zero flag under TT_SWEEP_STABILITY_EN
module tt_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic [7:0] load_val,
`ifdef TT_SWEEP_STABILITY_EN
    output logic       one,
`endif
    output logic       zero
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign zero = (cnt == 8'd0);
`ifdef TT_SWEEP_STABILITY_EN
    assign one  = (cnt == 8'd1);
`endif

endmodule

// File: rtl/tt_sweep_ctrl.sv
// rtl/tt_sweep_ctrl.sv - sweeps all 8 vectors of a 3-input gate and assembles its truth-table code
// Optional output-stability check is compiled in with TT_SWEEP_STABILITY_EN.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    tt_sweep_ctrl_if.slave   bus
);

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t            state;
    logic [N_IN-1:0]   idx;
    logic              busy_r;
    logic              done_r;
    logic              tt_valid_r;
    logic              match_r;
    logic [TT_W-1:0]   tt_result_r;
    logic [TT_W-1:0]   exp_cap;

    logic accept;
    logic settling;
    logic cnt_zero;
    logic tmr_load;
    logic all_stable;

    assign accept   = (state == IDLE) && bus.start && !bus.abort;
    assign settling = (state == SETTLE) && !bus.abort;
    assign tmr_load = accept || (settling && cnt_zero && idx != 3'd7);

`ifdef TT_SWEEP_STABILITY_EN
    logic cnt_one;
    logic early_smp;
    logic unstable_r;

    tt_settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .dec      (settling),
        .load_val (RELOAD),
        .one      (cnt_one),
        .zero     (cnt_zero)
    );

    // The cnt==1 sample is compared with the committed cnt==0 sample of the same vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            early_smp  <= 1'b0;
            unstable_r <= 1'b0;
        end else if (accept) begin
            early_smp  <= 1'b0;
            unstable_r <= 1'b0;
        end else if (settling) begin
            if (cnt_one)
                early_smp <= bus.gate_out;
            if (cnt_zero && bus.gate_out != early_smp)
                unstable_r <= 1'b1;
        end
    end

    assign all_stable   = !unstable_r;
    assign bus.unstable = unstable_r;
`else
    tt_settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .dec      (settling),
        .load_val (RELOAD),
        .zero     (cnt_zero)
    );

    assign all_stable   = 1'b1;
    assign bus.unstable = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 3'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            tt_valid_r  <= 1'b0;
            match_r     <= 1'b0;
            tt_result_r <= '0;
            exp_cap     <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        exp_cap    <= bus.expected_tt;
                        idx        <= 3'd0;
                        tt_valid_r <= 1'b0;
                        match_r    <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (bus.abort) begin
                        // Partial tt_result is deliberately kept for debug.
                        idx    <= 3'd0;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt_zero) begin
                        tt_result_r[vec_to_bit(idx)] <= bus.gate_out;
                        if (idx == 3'd7)
                            state <= DONE;
                        else
                            idx <= idx + 3'd1;
                    end
                end
                DONE: begin
                    done_r     <= 1'b1;
                    tt_valid_r <= 1'b1;
                    match_r    <= (tt_result_r == exp_cap) && all_stable;
                    busy_r     <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gate_in   = idx;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.tt_valid  = tt_valid_r;
    assign bus.match     = match_r;
    assign bus.tt_result = tt_result_r;

endmodule
